// File: rtl/write_queue_if.sv
// Wide-in / narrow-out stream bundle between a user kernel, write_queue and a leaf interface port.
interface write_queue_if #(
   parameter int IN_WIDTH  = 128,
   parameter int OUT_WIDTH = 32
);
   logic [IN_WIDTH-1:0]  din;
   logic                 vld_in;
   logic                 rdy_upward;
   logic [OUT_WIDTH-1:0] dout;
   logic                 vld_out;
   logic                 rdy_downward;

   modport master (
      output din, vld_in, rdy_downward,
      input  rdy_upward, dout, vld_out
   );

   modport slave (
      input  din, vld_in, rdy_downward,
      output rdy_upward, dout, vld_out
   );
endinterface

// File: rtl/write_queue.sv
// Wide-to-narrow down-converter: DEPTH-word FIFO feeding a slice serializer, LS slice first.
// A word accepted at edge k is loaded at k+1 and shown the following cycle; rdy_upward depends only on the registered count.
module write_queue #(
   parameter int IN_WIDTH  = 128,
   parameter int OUT_WIDTH = 32,
   parameter int DEPTH     = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ap_start,
   write_queue_if.slave bus,
   output logic         idle
);
   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int IDX_W = $clog2(RATIO);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [RATIO-1:0][OUT_WIDTH-1:0] word_t;

   word_t            mem [DEPTH];
   word_t            shreg;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic [IDX_W-1:0] idx;

   logic in_xfer;
   logic out_xfer;
   logic last_slice;
   logic load;

   assign bus.rdy_upward = ap_start && !reset && (count < CNT_W'(DEPTH));
   assign bus.vld_out    = busy && ap_start;
   assign bus.dout       = shreg[idx];

   assign in_xfer    = bus.vld_in && bus.rdy_upward;
   assign out_xfer   = bus.vld_out && bus.rdy_downward;
   assign last_slice = (idx == IDX_W'(RATIO - 1));
   // Reload on the last slice's transfer so consecutive words stream without a bubble.
   assign load       = ap_start && (count != '0) && (!busy || (last_slice && out_xfer));
   assign idle       = (count == '0) && !busy;

   always_ff @(posedge clk) begin
      if (in_xfer)
         mem[wr_ptr] <= bus.din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         busy   <= 1'b0;
         idx    <= '0;
         shreg  <= '0;
      end else begin
         if (in_xfer)
            wr_ptr <= wr_ptr + PTR_W'(1);

         case ({in_xfer, load})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         if (out_xfer) begin
            if (!last_slice)
               idx <= idx + IDX_W'(1);
            else
               busy <= 1'b0;
         end

         // Placed last so a same-edge reload overrides the end-of-word busy clear.
         if (load) begin
            shreg  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + PTR_W'(1);
            busy   <= 1'b1;
            idx    <= '0;
         end
      end
   end
endmodule

// File: tb/tb_write_queue.sv
// Directed bench for write_queue: inputs change and outputs are checked 1 ns after each falling edge.
module tb_write_queue;
   logic clk;
   logic reset;
   logic ap_start;
   logic idle;
   int   vec;
   int   errs;

   logic [127:0] words [8];

   write_queue_if #(.IN_WIDTH(128), .OUT_WIDTH(32)) bus ();

   write_queue #(.IN_WIDTH(128), .OUT_WIDTH(32), .DEPTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .ap_start (ap_start),
      .bus      (bus),
      .idle     (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] sl(input logic [127:0] w, input int i);
      return w[i*32 +: 32];
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; ap_start = 1'b1;
      bus.vld_in = 1'b0; bus.din = '0; bus.rdy_downward = 1'b1;
      tick(); tick(); #1;
      vec++; if (bus.rdy_upward !== 1'b0) begin errs++; $display("FAIL rst_rdy_during got=%b want=0", bus.rdy_upward); end
      tick(); reset = 1'b0; #1;
      vec++; if (bus.vld_out !== 1'b0) begin errs++; $display("FAIL rst_vld got=%b want=0", bus.vld_out); end
      vec++; if (bus.dout !== 32'h0) begin errs++; $display("FAIL rst_dout got=%h want=0", bus.dout); end
      vec++; if (idle !== 1'b1) begin errs++; $display("FAIL rst_idle got=%b want=1", idle); end
      vec++; if (bus.rdy_upward !== 1'b1) begin errs++; $display("FAIL rst_rdy got=%b want=1", bus.rdy_upward); end
   endtask

   task automatic test_single();
      logic [127:0] w;
      w = 128'h44444444_33333333_22222222_11111111;
      tick(); bus.din = w; bus.vld_in = 1'b1; bus.rdy_downward = 1'b1; #1;
      vec++; if (bus.rdy_upward !== 1'b1) begin errs++; $display("FAIL single_rdy got=%b want=1", bus.rdy_upward); end
      tick(); bus.vld_in = 1'b0; #1;
      vec++; if (bus.vld_out !== 1'b0) begin errs++; $display("FAIL single_early_vld got=%b want=0", bus.vld_out); end
      vec++; if (idle !== 1'b0) begin errs++; $display("FAIL single_busy_idle got=%b want=0", idle); end
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         vec++;
         if (bus.vld_out !== 1'b1 || bus.dout !== sl(w, i)) begin
            errs++; $display("FAIL single_slice%0d got vld=%b dout=%h want vld=1 dout=%h", i, bus.vld_out, bus.dout, sl(w, i));
         end
      end
      tick(); #1;
      vec++; if (bus.vld_out !== 1'b0 || idle !== 1'b1) begin errs++; $display("FAIL single_end got vld=%b idle=%b want vld=0 idle=1", bus.vld_out, idle); end
   endtask

   task automatic test_back_to_back();
      int got;
      bit started;
      got = 0; started = 1'b0;
      bus.rdy_downward = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (c < 3) begin bus.din = words[c]; bus.vld_in = 1'b1; end
         else bus.vld_in = 1'b0;
         #1;
         if (c < 3) begin
            vec++; if (bus.rdy_upward !== 1'b1) begin errs++; $display("FAIL stream_rdy c=%0d got=%b want=1", c, bus.rdy_upward); end
         end
         if (started && got < 12) begin
            vec++; if (bus.vld_out !== 1'b1) begin errs++; $display("FAIL stream_bubble c=%0d got vld=%b want 1", c, bus.vld_out); end
         end
         if (bus.vld_out === 1'b1 && got < 12) begin
            started = 1'b1;
            vec++;
            if (bus.dout !== sl(words[got/4], got%4)) begin
               errs++; $display("FAIL stream_slice%0d got=%h want=%h", got, bus.dout, sl(words[got/4], got%4));
            end
            got++;
         end
      end
      vec++; if (got != 12) begin errs++; $display("FAIL stream_count got=%0d want=12", got); end
      vec++; if (idle !== 1'b1) begin errs++; $display("FAIL stream_idle got=%b want=1", idle); end
   endtask

   task automatic test_full();
      int n;
      n = 0;
      bus.rdy_downward = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick(); bus.din = words[n]; bus.vld_in = 1'b1; #1;
         if (bus.rdy_upward === 1'b1 && n < 5) n++;
         else if (bus.rdy_upward === 1'b1) n++;
      end
      tick(); bus.vld_in = 1'b0; #1;
      vec++; if (n != 5) begin errs++; $display("FAIL full_accepted got=%0d want=5", n); end
      vec++; if (bus.rdy_upward !== 1'b0) begin errs++; $display("FAIL full_rdy got=%b want=0", bus.rdy_upward); end
      vec++; if (bus.vld_out !== 1'b1 || bus.dout !== sl(words[0], 0)) begin errs++; $display("FAIL full_hold got vld=%b dout=%h want vld=1 dout=%h", bus.vld_out, bus.dout, sl(words[0], 0)); end
      bus.rdy_downward = 1'b1;
      for (int j = 0; j < 20; j++) begin
         if (j > 0) begin tick(); #1; end
         vec++;
         if (bus.vld_out !== 1'b1 || bus.dout !== sl(words[j/4], j%4)) begin
            errs++; $display("FAIL full_drain%0d got vld=%b dout=%h want vld=1 dout=%h", j, bus.vld_out, bus.dout, sl(words[j/4], j%4));
         end
         vec++;
         if (bus.rdy_upward !== (j >= 4)) begin
            errs++; $display("FAIL full_rdy_drain%0d got=%b want=%b", j, bus.rdy_upward, (j >= 4));
         end
      end
      tick(); #1;
      vec++; if (idle !== 1'b1 || bus.vld_out !== 1'b0) begin errs++; $display("FAIL full_idle got idle=%b vld=%b want 1/0", idle, bus.vld_out); end
   endtask

   task automatic test_stall();
      int e;
      logic [127:0] w;
      w = words[6];
      e = 0;
      bus.rdy_downward = 1'b0;
      tick(); bus.din = w; bus.vld_in = 1'b1;
      tick(); bus.vld_in = 1'b0;
      for (int c = 0; c < 16 && e < 4; c++) begin
         tick(); bus.rdy_downward = (c % 2 == 0); #1;
         vec++;
         if (bus.vld_out !== 1'b1 || bus.dout !== sl(w, e)) begin
            errs++; $display("FAIL stall_c%0d got vld=%b dout=%h want vld=1 dout=%h", c, bus.vld_out, bus.dout, sl(w, e));
         end
         if (bus.rdy_downward) e++;
      end
      tick(); #1;
      vec++; if (e != 4 || bus.vld_out !== 1'b0) begin errs++; $display("FAIL stall_end got slices=%0d vld=%b want 4/0", e, bus.vld_out); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] b;
      b = words[7];
      bus.rdy_downward = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); bus.din = words[i]; bus.vld_in = 1'b1;
      end
      tick(); bus.vld_in = 1'b0; bus.rdy_downward = 1'b1; #1;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) begin tick(); #1; end
         vec++; if (bus.dout !== sl(words[0], i)) begin errs++; $display("FAIL rmid_a%0d got=%h want=%h", i, bus.dout, sl(words[0], i)); end
      end
      tick(); reset = 1'b1; bus.rdy_downward = 1'b0;
      tick(); reset = 1'b0; #1;
      vec++;
      if (bus.vld_out !== 1'b0 || idle !== 1'b1 || bus.rdy_upward !== 1'b1) begin
         errs++; $display("FAIL rmid_after got vld=%b idle=%b rdy=%b want 0/1/1", bus.vld_out, idle, bus.rdy_upward);
      end
      bus.din = b; bus.vld_in = 1'b1; bus.rdy_downward = 1'b1;
      tick(); bus.vld_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         vec++;
         if (bus.vld_out !== 1'b1 || bus.dout !== sl(b, i)) begin
            errs++; $display("FAIL rmid_b%0d got vld=%b dout=%h want vld=1 dout=%h", i, bus.vld_out, bus.dout, sl(b, i));
         end
      end
      tick(); #1;
      vec++; if (bus.vld_out !== 1'b0 || idle !== 1'b1) begin errs++; $display("FAIL rmid_end got vld=%b idle=%b want 0/1", bus.vld_out, idle); end
   endtask

   task automatic test_ap_start();
      logic [127:0] w;
      w = words[5];
      bus.rdy_downward = 1'b1;
      tick(); bus.din = w; bus.vld_in = 1'b1;
      tick(); bus.vld_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick(); #1;
         vec++; if (bus.dout !== sl(w, i)) begin errs++; $display("FAIL aps_pre%0d got=%h want=%h", i, bus.dout, sl(w, i)); end
      end
      for (int c = 0; c < 3; c++) begin
         tick(); ap_start = 1'b0; bus.din = words[0]; bus.vld_in = 1'b1; #1;
         vec++;
         if (bus.vld_out !== 1'b0 || bus.rdy_upward !== 1'b0 || idle !== 1'b0 || bus.dout !== sl(w, 2)) begin
            errs++; $display("FAIL aps_low%0d got vld=%b rdy=%b idle=%b dout=%h want 0/0/0/%h", c, bus.vld_out, bus.rdy_upward, idle, bus.dout, sl(w, 2));
         end
      end
      for (int i = 2; i < 4; i++) begin
         tick(); ap_start = 1'b1; bus.vld_in = 1'b0; #1;
         vec++;
         if (bus.vld_out !== 1'b1 || bus.dout !== sl(w, i)) begin
            errs++; $display("FAIL aps_resume%0d got vld=%b dout=%h want vld=1 dout=%h", i, bus.vld_out, bus.dout, sl(w, i));
         end
      end
      tick(); #1;
      vec++; if (idle !== 1'b1 || bus.vld_out !== 1'b0) begin errs++; $display("FAIL aps_end got idle=%b vld=%b want 1/0", idle, bus.vld_out); end
   endtask

   initial begin
      vec = 0; errs = 0;
      for (int i = 0; i < 8; i++)
         words[i] = {32'(32'hA000_0003 + i*16), 32'(32'hA000_0002 + i*16),
                     32'(32'hA000_0001 + i*16), 32'(32'hA000_0000 + i*16)};
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_stall();
      test_reset_mid();
      test_ap_start();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/write_queue.md
Name: write_queue

Overview:
- Width down-converter for the user-to-interface direction of a page.
- Accepts wide IN_WIDTH words from a user kernel output stream and emits them as OUT_WIDTH slices, least-significant slice first, toward a leaf_interface output port (din_leaf_user2interface / vld_user2interface / ack_interface2user).
- Buffers up to DEPTH wide words so a kernel can burst while the interface is backpressured.
- Mirror of the narrow-to-wide input converter on the interface-to-user side.

Parameters:
- IN_WIDTH, 128, wide user-side word width; must be an integer multiple of OUT_WIDTH, ratio ≥ 2.
- OUT_WIDTH, 32, narrow interface-side payload width.
- DEPTH, 4, wide-word FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  run enable; low freezes the block.
- din  in  IN_WIDTH  wide word from user kernel.
- vld_in  in  1  din valid.
- rdy_upward  out  1  block can accept din this cycle.
- dout  out  OUT_WIDTH  current narrow slice to interface.
- vld_out  out  1  dout valid.
- rdy_downward  in  1  interface accepts dout this cycle.
- idle  out  1  FIFO empty and serializer not busy.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Constants: RATIO = IN_WIDTH/OUT_WIDTH. Slice index width = clog2(RATIO). Count width = clog2(DEPTH)+1.
- Handshake rules:
  - Input transfer on a rising edge with vld_in && rdy_upward.
  - Output transfer on a rising edge with vld_out && rdy_downward.
  - Valid/ready semantics: the producer must not drop valid or change data until the transfer completes.
- Reset values: count=0, wr_ptr=0, rd_ptr=0, busy=0, idx=0, shift register=0, vld_out=0, dout=0, idle=1.
- rdy_upward = ap_start && !reset && (count < DEPTH).
  - Registered-count based only; no combinational path from rdy_downward.
  - A full FIFO stays not-ready in a cycle where it is also being read.
- FIFO write: on an input transfer, mem[wr_ptr] <= din, wr_ptr wraps modulo DEPTH.
- Serializer load:
  - Condition: ap_start && count>0 && (!busy || (idx==RATIO-1 && output transfer)).
  - Action: shreg <= mem[rd_ptr], rd_ptr wraps, busy <= 1, idx <= 0.
- count update: +1 on write only, −1 on load only, unchanged on simultaneous write and load.
- Output datapath:
  - dout = shreg[idx*OUT_WIDTH +: OUT_WIDTH].
  - vld_out = busy && ap_start.
- Slice advance: on an output transfer, if idx<RATIO-1 then idx++; else busy <= 0 unless a reload happens in the same edge.
- Latency and throughput:
  - Word accepted at edge k is written to the FIFO; it is loaded at edge k+1 if the serializer is idle.
  - vld_out is high in the cycle after edge k+1; first slice = din[OUT_WIDTH-1:0].
  - Back-to-back words with rdy_downward=1 produce one slice every cycle with no bubble between words.
- Capacity: DEPTH words in the FIFO plus 1 in the serializer.
- Backpressure: while vld_out && !rdy_downward, dout, idx and shreg hold stable.
- ap_start low:
  - rdy_upward=0 and vld_out=0.
  - No load and no slice advance; all state held.
  - On re-raise, resumes at the same slice.
- Reset mid-operation: all buffered words and any partial word are discarded; the next accepted word starts at slice 0.
- idle = (count==0) && !busy.

Test Plan:
- Single word, ap_start=1, rdy_downward=1: din=0x44444444_33333333_22222222_11111111 accepted at edge k -> vld_out rises after edge k+1; dout = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles; then idle=1.
- Streaming, rdy_downward=1: 3 back-to-back words W0..W2 -> 12 consecutive vld_out cycles with no bubble, slices in order W0[0..3], W1[0..3], W2[0..3]; rdy_upward never drops.
- Full, rdy_downward=0: offer 6 words -> exactly 5 accepted (1 in serializer + 4 in FIFO), rdy_upward=0 from then on. Raise rdy_downward -> 20 slices in order; rdy_upward reasserts the cycle after count drops below 4.
- Stall mid-word: rdy_downward toggles 1,0,1,0 -> dout and idx hold stable during every vld_out && !rdy_downward cycle; all slices are delivered exactly once, in order.
- Reset mid-word: reset pulsed for 1 cycle after 2 slices of word A with 2 more words queued -> next cycle vld_out=0, idle=1, rdy_upward=1. New word B emits B slice 0 first; no A data appears.
- ap_start drop: ap_start=0 after slice 1 of a word -> vld_out=0 and rdy_upward=0 while low, no state change. On re-raise, dout resumes at slice 2.
